// File: rtl/clstm_result_collector_if.sv
// Result-frame bus between the C-LSTM datapath and the collector: one wide
// frame handshake in, one word-serial valid/ready stream out.
interface clstm_result_collector_if #(
  parameter int WIDTH  = 18,
  parameter int LANES  = 16,
  parameter int GROUPS = 3
);
  logic                             in_valid;
  logic                             in_ready;
  logic [GROUPS*LANES*WIDTH-1:0]    in_data;
  logic                             out_valid;
  logic                             out_ready;
  logic [WIDTH-1:0]                 out_data;
  logic                             out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/clstm_result_collector.sv
// Captures a whole C-LSTM output frame, drains it word-serially and folds every
// drained word into a 32-bit MISR. Optional checker: CLSTM_COLLECT_ORDER_CHECK_EN.
module clstm_result_collector #(
  parameter int          WIDTH  = 18,
  parameter int          LANES  = 16,
  parameter int          GROUPS = 3,
  parameter logic [31:0] POLY   = 32'h04C11DB7
) (
  input  logic                     clk,
  input  logic                     rst,
  clstm_result_collector_if.slave  bus,
  output logic [31:0]              signature,
  output logic [15:0]              frame_count,
  output logic                     busy
`ifdef CLSTM_COLLECT_ORDER_CHECK_EN
  ,
  output logic                     order_err
`endif
);
  localparam int N  = GROUPS * LANES;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                   state, state_nx;
  logic [IW-1:0]            idx;
  logic [N-1:0][WIDTH-1:0]  bank;
  logic                     accept, fire, last;

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [WIDTH-1:0] w);
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ 32'(w);
  endfunction

  assign last = (idx == IW'(N - 1));
  assign busy = (state == SEND);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    accept        = 1'b0;
    fire          = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept   = 1'b1;
          state_nx = SEND;
        end
      end
      SEND: begin
        bus.out_valid = 1'b1;
        bus.out_data  = bank[idx];
        bus.out_last  = last;
        fire          = bus.out_ready;
        if (fire && last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The bank only samples in_data on an accepted handshake, so whatever the
  // source does with in_data at other times never reaches the outputs.
  always_ff @(posedge clk) begin
    if (accept) bank <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx         <= '0;
      signature   <= 32'h0;
      frame_count <= 16'h0;
    end else if (accept) begin
      idx <= '0;
    end else if (fire) begin
      signature <= misr_step(signature, bank[idx]);
      if (last) begin
        idx         <= '0;
        frame_count <= frame_count + 16'h1;
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

`ifdef CLSTM_COLLECT_ORDER_CHECK_EN
  localparam int CW = $clog2(2 * N + 1);

  logic             prev_stall;
  logic [WIDTH-1:0] prev_data;
  logic [CW-1:0]    hold_cnt;

  // Sticky protocol watchdog: a stalled word must stay put, and a source
  // pushing a new frame must not be kept waiting past two frame drains.
  always_ff @(posedge clk) begin
    if (!rst) begin
      order_err  <= 1'b0;
      prev_stall <= 1'b0;
      prev_data  <= '0;
      hold_cnt   <= '0;
    end else begin
      prev_stall <= bus.out_valid && !bus.out_ready;
      prev_data  <= bus.out_data;
      if (prev_stall && (!bus.out_valid || bus.out_data != prev_data)) order_err <= 1'b1;
      if (bus.in_valid && busy) begin
        if (hold_cnt == CW'(2 * N)) order_err <= 1'b1;
        else                         hold_cnt  <= hold_cnt + CW'(1);
      end else begin
        hold_cnt <= '0;
      end
    end
  end
`endif
endmodule

// File: tb/tb_clstm_result_collector.sv
// Self-checking bench for clstm_result_collector: a cycle table for reset and
// handshake basics, then frame-level sequences against a stream/MISR model.
module tb_clstm_result_collector;
  localparam int          WIDTH  = 18;
  localparam int          LANES  = 16;
  localparam int          GROUPS = 3;
  localparam int          N      = GROUPS * LANES;
  localparam logic [31:0] POLY   = 32'h04C11DB7;

  typedef logic [N-1:0][WIDTH-1:0] frame_t;

  typedef struct {
    bit          rst_n;
    bit          iv;
    bit          ordy;
    bit          e_irdy;
    bit          e_ov;
    bit          e_last;
    logic [17:0] e_data;
    logic [31:0] e_sig;
    bit          e_busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] signature;
  logic [15:0] frame_count;
  logic        busy;
`ifdef CLSTM_COLLECT_ORDER_CHECK_EN
  logic        order_err;
`endif

  always #5 clk = ~clk;

  clstm_result_collector_if #(.WIDTH(WIDTH), .LANES(LANES), .GROUPS(GROUPS)) bus();

  clstm_result_collector #(.WIDTH(WIDTH), .LANES(LANES), .GROUPS(GROUPS), .POLY(POLY)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .signature   (signature),
    .frame_count (frame_count),
    .busy        (busy)
`ifdef CLSTM_COLLECT_ORDER_CHECK_EN
    ,
    .order_err   (order_err)
`endif
  );

  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_sig = 32'h0;
  logic [15:0] m_fc = 16'h0;
  vec_t        tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Signature as a running polynomial fold over the drained word stream.
  function automatic logic [31:0] model_fold(input logic [31:0] s, input logic [WIDTH-1:0] w);
    logic [31:0] t;
    t = s << 1;
    if (s[31]) t = t ^ POLY;
    return t ^ {14'h0, w};
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int k = 0; k < N; k++) f[k] = WIDTH'($urandom);
    return f;
  endfunction

  function automatic frame_t ramp_frame();
    frame_t f;
    for (int k = 0; k < N; k++) f[k] = WIDTH'(k);
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    m_sig = 32'h0;
    m_fc = 16'h0;
    rst = 1'b1;
  endtask

  task automatic accept(input frame_t f, input bit hold);
    bus.in_data = f;
    bus.in_valid = 1'b1;
    tick();
    if (!hold) bus.in_valid = 1'b0;
    chk("accept_busy", busy, 1);
  endtask

  // mode 0: always ready, 1: 1,0,0,1 pattern, 2: random
  task automatic drain(input frame_t f, input int mode, input int stop_at);
    int pos = 0;
    int cyc = 0;
    bit r;
    while (pos < stop_at && cyc < 20 * N) begin
      chk("out_valid", bus.out_valid, 1);
      chk("out_data", bus.out_data, f[pos]);
      chk("out_last", bus.out_last, (pos == N - 1));
      chk("in_ready_send", bus.in_ready, 0);
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: r = ($urandom_range(0, 1) == 1);
      endcase
      bus.out_ready = r;
      tick();
      cyc++;
      if (r) begin
        m_sig = model_fold(m_sig, f[pos]);
        pos++;
        if (pos == N) m_fc = m_fc + 16'h1;
      end
    end
    bus.out_ready = 1'b0;
    if (pos < stop_at) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d words expected %0d", pos, stop_at);
    end
    if (stop_at == N) begin
      chk("post_out_valid", bus.out_valid, 0);
      chk("post_in_ready", bus.in_ready, 1);
      chk("frame_count", frame_count, m_fc);
      chk("signature", signature, m_sig);
    end
  endtask

  initial begin
    frame_t      f1, f2, fz;
    logic [31:0] sig_a;

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_data = ramp_frame();

    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'd0, 32'h0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'd0, 32'h0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 18'd0, 32'h0, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 18'd0, 32'h0, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 18'd0, 32'h0, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 18'd1, 32'h0, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 18'd2, 32'h1, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 18'd2, 32'h1, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'd0, 32'h0, 1'b0};

    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst_n;
      bus.in_valid = tbl[i].iv;
      bus.out_ready = tbl[i].ordy;
      tick();
      chk($sformatf("tbl%0d_in_ready", i), bus.in_ready, tbl[i].e_irdy);
      chk($sformatf("tbl%0d_out_valid", i), bus.out_valid, tbl[i].e_ov);
      chk($sformatf("tbl%0d_out_last", i), bus.out_last, tbl[i].e_last);
      chk($sformatf("tbl%0d_out_data", i), bus.out_data, tbl[i].e_data);
      chk($sformatf("tbl%0d_signature", i), signature, tbl[i].e_sig);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      if (!tbl[i].rst_n) chk($sformatf("tbl%0d_frame_count", i), frame_count, 0);
    end

    // ramp frame at full rate
    do_reset();
    accept(ramp_frame(), 1'b0);
    drain(ramp_frame(), 0, N);
    chk("ramp_fc1", frame_count, 1);
    sig_a = m_sig;

    // same frame with 1,0,0,1 back-pressure must give the same signature
    do_reset();
    accept(ramp_frame(), 1'b0);
    drain(ramp_frame(), 1, N);
    chk("toggle_sig_same", signature, sig_a);

    // back-to-back frames with in_valid held high
    do_reset();
    f1 = rand_frame();
    f2 = rand_frame();
    accept(f1, 1'b1);
    bus.in_data = f2;
    drain(f1, 0, N);
    tick();
    chk("b2b_second_accept", busy, 1);
    bus.in_valid = 1'b0;
    drain(f2, 0, N);
    chk("b2b_fc2", frame_count, 2);

    // reset in the middle of a drain
    f1 = rand_frame();
    accept(f1, 1'b0);
    drain(f1, 0, 20);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    m_sig = 32'h0;
    m_fc = 16'h0;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_signature", signature, 0);
    chk("midrst_frame_count", frame_count, 0);
    for (int k = 0; k < N; k++) f2[k] = 18'h3FFFF;
    accept(f2, 1'b0);
    drain(f2, 0, N);

    // all-zero frame, then a single one in word 0
    do_reset();
    fz = '0;
    accept(fz, 1'b0);
    drain(fz, 0, N);
    chk("zero_sig", signature, 0);
    f1 = '0;
    f1[0] = 18'h00001;
    accept(f1, 1'b0);
    drain(f1, 0, N);

    // random frames, random gaps and random back-pressure
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      f1 = rand_frame();
      accept(f1, 1'b0);
      drain(f1, 2, N);
    end

`ifdef CLSTM_COLLECT_ORDER_CHECK_EN
    do_reset();
    chk("oe_reset", order_err, 0);
    accept(ramp_frame(), 1'b1);
    for (int c = 0; c < 96; c++) begin
      if (c < 5) bus.in_data = rand_frame();
      tick();
      if (c == 5) chk("oe_stall_data_isolated", order_err, 0);
    end
    chk("oe_96_cycles", order_err, 0);
    tick();
    chk("oe_97_cycles", order_err, 1);
    bus.in_valid = 1'b0;
    drain(ramp_frame(), 0, N);
    chk("oe_sticky", order_err, 1);
    do_reset();
    chk("oe_cleared", order_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
